// File: rtl/force_overlay_unit_if.sv
// Command/response channel bundle for force_overlay_unit.
// The master side issues commands and accepts responses; the slave side is the overlay.
interface force_overlay_unit_if #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 4
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd_op;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_mask;
   logic [DATA_W-1:0] cmd_data;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_data;
   logic [DATA_W-1:0] rsp_fmask;
   logic              rsp_err;

   modport master (
      output cmd_valid, cmd_op, cmd_addr, cmd_mask, cmd_data, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_data, rsp_fmask, rsp_err
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_addr, cmd_mask, cmd_data, rsp_ready,
      output cmd_ready, rsp_valid, rsp_data, rsp_fmask, rsp_err
   );
endinterface

// File: rtl/force_overlay_unit.sv
// Force/release overlay: per-slot driver value, force value and force mask, resolved like SV force/release.
// Define FORCE_OVERLAY_STATS_EN to add saturating force/release/error counters.
module force_overlay_unit #(
   parameter int NUM_SIG = 12,
   parameter int DATA_W  = 64,
   parameter int ADDR_W  = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_SIG-1:0]        drv_we,
   input  logic [NUM_SIG*DATA_W-1:0] drv_data,
   force_overlay_unit_if.slave       bus,
   output logic [NUM_SIG*DATA_W-1:0] sig_out,
   output logic                      any_forced
`ifdef FORCE_OVERLAY_STATS_EN
   ,
   output logic [15:0]               force_cnt,
   output logic [15:0]               release_cnt,
   output logic [15:0]               err_cnt
`endif
);

   typedef enum logic {IDLE, RESP} state_t;
   typedef enum logic [1:0] {OP_NOP, OP_FORCE, OP_RELEASE, OP_READ} op_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] drv_q [NUM_SIG];
   logic [DATA_W-1:0] fv_q  [NUM_SIG];
   logic [DATA_W-1:0] fm_q  [NUM_SIG];
   logic [DATA_W-1:0] drv_n [NUM_SIG];
   logic [DATA_W-1:0] fv_n  [NUM_SIG];
   logic [DATA_W-1:0] fm_n  [NUM_SIG];
   logic [DATA_W-1:0] rsp_data_q, rsp_fmask_q, sel_data, sel_mask;
   logic              rsp_err_q;
   logic              accept, addr_ok;
   op_t               op;

   function automatic logic [DATA_W-1:0] resolve(input logic [DATA_W-1:0] d,
                                                 input logic [DATA_W-1:0] v,
                                                 input logic [DATA_W-1:0] m);
      return (v & m) | (d & ~m);
   endfunction

   assign op            = op_t'(bus.cmd_op);
   assign addr_ok       = 32'(bus.cmd_addr) < 32'(NUM_SIG);
   assign bus.cmd_ready = (state_q == IDLE) && !rst;
   assign accept        = bus.cmd_valid && bus.cmd_ready;
   assign bus.rsp_valid = (state_q == RESP);
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_fmask = rsp_fmask_q;
   assign bus.rsp_err   = rsp_err_q;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (accept) state_d = RESP;
         RESP: if (bus.rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Driver write is applied after the command so that it wins over a simultaneous release.
   always_comb begin
      drv_n    = drv_q;
      fv_n     = fv_q;
      fm_n     = fm_q;
      sel_data = '0;
      sel_mask = '0;
      for (int unsigned i = 0; i < NUM_SIG; i++) begin
         if (accept && addr_ok && bus.cmd_addr == ADDR_W'(i)) begin
            if (op == OP_FORCE) begin
               fv_n[i] = (fv_q[i] & ~bus.cmd_mask) | (bus.cmd_data & bus.cmd_mask);
               fm_n[i] = fm_q[i] | bus.cmd_mask;
            end else if (op == OP_RELEASE) begin
               drv_n[i] = (drv_q[i] & ~(bus.cmd_mask & fm_q[i]))
                        | (fv_q[i] & bus.cmd_mask & fm_q[i]);
               fm_n[i]  = fm_q[i] & ~bus.cmd_mask;
            end
         end
         if (drv_we[i]) drv_n[i] = drv_data[i*DATA_W +: DATA_W];
         if (addr_ok && bus.cmd_addr == ADDR_W'(i)) begin
            sel_data = resolve(drv_n[i], fv_n[i], fm_n[i]);
            sel_mask = fm_n[i];
         end
      end
   end

   always_comb begin
      sig_out    = '0;
      any_forced = 1'b0;
      for (int unsigned i = 0; i < NUM_SIG; i++) begin
         sig_out[i*DATA_W +: DATA_W] = resolve(drv_q[i], fv_q[i], fm_q[i]);
         any_forced = any_forced | (|fm_q[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         rsp_data_q  <= '0;
         rsp_fmask_q <= '0;
         rsp_err_q   <= 1'b0;
         for (int unsigned i = 0; i < NUM_SIG; i++) begin
            drv_q[i] <= '0;
            fv_q[i]  <= '0;
            fm_q[i]  <= '0;
         end
      end else begin
         state_q <= state_d;
         drv_q   <= drv_n;
         fv_q    <= fv_n;
         fm_q    <= fm_n;
         if (accept) begin
            rsp_data_q  <= sel_data;
            rsp_fmask_q <= sel_mask;
            rsp_err_q   <= !addr_ok;
         end
      end
   end

`ifdef FORCE_OVERLAY_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         force_cnt   <= '0;
         release_cnt <= '0;
         err_cnt     <= '0;
      end else if (accept) begin
         if (op == OP_FORCE && force_cnt != '1)     force_cnt   <= force_cnt + 16'd1;
         if (op == OP_RELEASE && release_cnt != '1) release_cnt <= release_cnt + 16'd1;
         if (!addr_ok && err_cnt != '1)             err_cnt     <= err_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_force_overlay_unit.sv
// Directed bench for force_overlay_unit with a per-bit force/release model compared every cycle.
// Counter ports are checked when FORCE_OVERLAY_STATS_EN is defined.
module tb_force_overlay_unit;
   localparam int NS = 12;
   localparam int DW = 64;
   localparam int AW = 4;
   localparam logic [1:0] NOP = 2'd0, FRC = 2'd1, REL = 2'd2, RD = 2'd3;
   localparam logic [DW-1:0] ONES = '1;

   logic               clk = 1'b0;
   logic               rst;
   logic [NS-1:0]      drv_we;
   logic [NS*DW-1:0]   drv_data;
   logic [NS*DW-1:0]   sig_out;
   logic               any_forced;
`ifdef FORCE_OVERLAY_STATS_EN
   logic [15:0]        force_cnt, release_cnt, err_cnt;
   int                 m_fcnt, m_rcnt, m_ecnt;
`endif

   force_overlay_unit_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   force_overlay_unit #(.NUM_SIG(NS), .DATA_W(DW), .ADDR_W(AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .drv_we     (drv_we),
      .drv_data   (drv_data),
      .bus        (bus.slave),
      .sig_out    (sig_out),
      .any_forced (any_forced)
`ifdef FORCE_OVERLAY_STATS_EN
      ,
      .force_cnt  (force_cnt),
      .release_cnt(release_cnt),
      .err_cnt    (err_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   function automatic void chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endfunction

   // Model: each bit is either forced (shows its force value) or follows its last assigned value.
   logic [DW-1:0] m_drv [NS];
   logic [DW-1:0] m_fv  [NS];
   logic [DW-1:0] m_frc [NS];
   bit            m_busy;
   logic [DW-1:0] m_rdata, m_rmask;
   logic          m_rerr;

   function automatic logic [DW-1:0] mres(int s);
      logic [DW-1:0] r;
      for (int b = 0; b < DW; b++) r[b] = m_frc[s][b] ? m_fv[s][b] : m_drv[s][b];
      return r;
   endfunction

   always @(posedge clk) begin : model
      bit acc, err;
      int a;
      if (rst) begin
         for (int s = 0; s < NS; s++) begin
            m_drv[s] = '0; m_fv[s] = '0; m_frc[s] = '0;
         end
         m_busy = 0; m_rdata = '0; m_rmask = '0; m_rerr = 0;
`ifdef FORCE_OVERLAY_STATS_EN
         m_fcnt = 0; m_rcnt = 0; m_ecnt = 0;
`endif
      end else begin
         acc = !m_busy && bus.cmd_valid;
         a   = int'(bus.cmd_addr);
         err = a >= NS;
         if (acc && !err) begin
            for (int b = 0; b < DW; b++) begin
               if (bus.cmd_mask[b] && bus.cmd_op == FRC) begin
                  m_frc[a][b] = 1'b1;
                  m_fv[a][b]  = bus.cmd_data[b];
               end else if (bus.cmd_mask[b] && bus.cmd_op == REL) begin
                  if (m_frc[a][b]) m_drv[a][b] = m_fv[a][b];
                  m_frc[a][b] = 1'b0;
               end
            end
         end
         for (int s = 0; s < NS; s++)
            if (drv_we[s]) m_drv[s] = drv_data[s*DW +: DW];
         if (acc) begin
            m_busy  = 1;
            m_rerr  = err;
            m_rdata = err ? '0 : mres(a);
            m_rmask = err ? '0 : m_frc[a];
`ifdef FORCE_OVERLAY_STATS_EN
            if (bus.cmd_op == FRC && m_fcnt < 16'hFFFF) m_fcnt++;
            if (bus.cmd_op == REL && m_rcnt < 16'hFFFF) m_rcnt++;
            if (err && m_ecnt < 16'hFFFF) m_ecnt++;
`endif
         end else if (m_busy && bus.rsp_ready) begin
            m_busy = 0;
         end
      end
   end

   always @(negedge clk) begin : compare
      bit anyf;
      if (chk_en) begin
         anyf = 0;
         for (int s = 0; s < NS; s++) begin
            chk($sformatf("sig_out[%0d]", s), sig_out[s*DW +: DW], mres(s));
            anyf = anyf | (|m_frc[s]);
         end
         chk("any_forced", DW'(any_forced), DW'(anyf));
         chk("cmd_ready", DW'(bus.cmd_ready), DW'(!m_busy && !rst));
         chk("rsp_valid", DW'(bus.rsp_valid), DW'(m_busy));
         chk("rsp_data", bus.rsp_data, m_rdata);
         chk("rsp_fmask", bus.rsp_fmask, m_rmask);
         chk("rsp_err", DW'(bus.rsp_err), DW'(m_rerr));
`ifdef FORCE_OVERLAY_STATS_EN
         chk("force_cnt", DW'(force_cnt), DW'(m_fcnt));
         chk("release_cnt", DW'(release_cnt), DW'(m_rcnt));
         chk("err_cnt", DW'(err_cnt), DW'(m_ecnt));
`endif
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_drv(int s, logic [DW-1:0] v, bit we);
      drv_data[s*DW +: DW] = v;
      drv_we[s] = we;
   endtask

   function automatic logic [DW-1:0] slot(int s);
      return sig_out[s*DW +: DW];
   endfunction

   task automatic send(logic [1:0] op, int addr, logic [DW-1:0] mask, logic [DW-1:0] data);
      int n = 0;
      bus.cmd_op    = op;
      bus.cmd_addr  = AW'(addr);
      bus.cmd_mask  = mask;
      bus.cmd_data  = data;
      bus.cmd_valid = 1'b1;
      while (!bus.cmd_ready && n < 20) begin
         step();
         n++;
      end
      chk("cmd_ready_wait", DW'(bus.cmd_ready), DW'(1));
      step();
      bus.cmd_valid = 1'b0;
   endtask

   task automatic finish_rsp(int hold);
      repeat (hold) step();
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      logic [DW-1:0] held;
      rst = 1'b1; drv_we = '0; drv_data = '0;
      bus.cmd_valid = 1'b0; bus.cmd_op = NOP; bus.cmd_addr = '0;
      bus.cmd_mask = '0; bus.cmd_data = '0; bus.rsp_ready = 1'b0;
      step();
      chk_en = 1'b1;
      step();
      chk("reset sig_out1", slot(1), '0);
      chk("reset rsp_valid", DW'(bus.rsp_valid), '0);
      chk("reset cmd_ready", DW'(bus.cmd_ready), '0);
      rst = 1'b0;
      step();

      // Full force while the driver keeps writing.
      set_drv(1, 64'hAAAAAAAA, 1'b1);
      step();
      send(FRC, 1, 64'hFFFFFFFF, 64'h55555555);
      chk("full rsp_data", bus.rsp_data, 64'h55555555);
      chk("full rsp_fmask", bus.rsp_fmask, 64'hFFFFFFFF);
      chk("full any_forced", DW'(any_forced), DW'(1));
      finish_rsp(0);
      step(); step();
      chk("full hold sig1", slot(1), 64'h55555555);

      // Release under an active driver, then partial force/release.
      send(REL, 1, 64'hFFFFFFFF, '0);
      chk("rel drv sig1", slot(1), 64'hAAAAAAAA);
      finish_rsp(0);
      send(FRC, 1, 64'h0000FFFF, 64'h5555);
      chk("part sig1", slot(1), 64'hAAAA5555);
      chk("part rsp_fmask", bus.rsp_fmask, 64'h0000FFFF);
      finish_rsp(1);
      set_drv(1, 64'hAAAAAAAA, 1'b0);
      send(REL, 1, 64'h0000FFFF, '0);
      chk("part rel sig1", slot(1), 64'hAAAA5555);
      chk("part rel any_forced", DW'(any_forced), '0);
      finish_rsp(0);
      step(); step();
      chk("part rel hold", slot(1), 64'hAAAA5555);
      set_drv(1, 64'hAAAAAAAA, 1'b1);
      step();
      chk("part rel redrive", slot(1), 64'hAAAAAAAA);
      drv_we[1] = 1'b0;

      // Simultaneous driver write and release: the driver wins.
      send(FRC, 3, ONES, 64'h55);
      finish_rsp(0);
      set_drv(3, 64'hAA, 1'b1);
      send(REL, 3, ONES, '0);
      drv_we[3] = 1'b0;
      chk("simul sig3", slot(3), 64'hAA);
      chk("simul rsp_data", bus.rsp_data, 64'hAA);
      finish_rsp(0);

      // Backpressure on a READ of a partially forced slot.
      set_drv(2, 64'h123456789ABCDEF0, 1'b1);
      step();
      drv_we[2] = 1'b0;
      send(FRC, 2, 64'hFF00, 64'hABCD);
      chk("slot2 force", slot(2), 64'h123456789ABCABF0);
      finish_rsp(0);
      send(RD, 2, '0, '0);
      held = bus.rsp_data;
      chk("read rsp_data", held, 64'h123456789ABCABF0);
      chk("read rsp_fmask", bus.rsp_fmask, 64'hFF00);
      for (int k = 0; k < 5; k++) begin
         step();
         chk("bp rsp_valid", DW'(bus.rsp_valid), DW'(1));
         chk("bp cmd_ready", DW'(bus.cmd_ready), '0);
         chk("bp rsp_data", bus.rsp_data, 64'h123456789ABCABF0);
      end
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
      chk("bp release valid", DW'(bus.rsp_valid), '0);
      chk("bp release ready", DW'(bus.cmd_ready), DW'(1));

      // Address boundaries, mask=0 and the last slot.
      send(FRC, 13, ONES, ONES);
      chk("err13 rsp_err", DW'(bus.rsp_err), DW'(1));
      chk("err13 rsp_data", bus.rsp_data, '0);
      chk("err13 rsp_fmask", bus.rsp_fmask, '0);
      chk("err13 sig2", slot(2), 64'h123456789ABCABF0);
      finish_rsp(0);
      send(RD, 12, '0, '0);
      chk("err12 rsp_err", DW'(bus.rsp_err), DW'(1));
      finish_rsp(0);
      send(FRC, 11, 64'hFF, 64'h3C);
      chk("slot11 rsp_err", DW'(bus.rsp_err), '0);
      chk("slot11 rsp_data", bus.rsp_data, 64'h3C);
      finish_rsp(0);
      send(FRC, 5, '0, ONES);
      chk("mask0 rsp_valid", DW'(bus.rsp_valid), DW'(1));
      chk("mask0 rsp_fmask", bus.rsp_fmask, '0);
      finish_rsp(0);
`ifdef FORCE_OVERLAY_STATS_EN
      chk("err_cnt literal", DW'(err_cnt), DW'(2));
`endif

      // Reset while a response is pending.
      send(RD, 2, '0, '0);
      rst = 1'b1;
      step();
      chk("rst rsp_valid", DW'(bus.rsp_valid), '0);
      chk("rst cmd_ready", DW'(bus.cmd_ready), '0);
      chk("rst any_forced", DW'(any_forced), '0);
      for (int s = 0; s < NS; s++) chk("rst sig_out", slot(s), '0);
      rst = 1'b0;
      step();
      chk("post rst cmd_ready", DW'(bus.cmd_ready), DW'(1));
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/force_overlay_unit.md
Name: force_overlay_unit

Overview:
- Force/release overlay stage sitting between the design's procedural drivers and the signal consumers (checkers, trace, VPI-visible readback).
- Holds up to NUM_SIG signal slots, each with a last-driven value, a force value and a per-bit force mask.
- Publishes the resolved value of every slot, so full and partial (bit-sliced) forces behave like SV force/release on variables.
- Commands arrive over a valid/ready command channel and are acknowledged over a valid/ready response channel.

Parameters:
- NUM_SIG, 12, number of signal slots
- DATA_W, 64, slot width in bits; narrower signals use the LSBs
- ADDR_W, 4, command address width; must satisfy 2**ADDR_W >= NUM_SIG

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- drv_we  in  NUM_SIG  per-slot driver write strobe
- drv_data  in  NUM_SIG*DATA_W  driver values; slot i occupies bits [i*DATA_W +: DATA_W]
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command ready
- cmd_op  in  2  operation: 0 NOP, 1 FORCE, 2 RELEASE, 3 READ
- cmd_addr  in  ADDR_W  slot index
- cmd_mask  in  DATA_W  bits affected by FORCE/RELEASE
- cmd_data  in  DATA_W  force value
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_data  out  DATA_W  resolved slot value after the command
- rsp_fmask  out  DATA_W  slot force mask after the command
- rsp_err  out  1  cmd_addr >= NUM_SIG
- sig_out  out  NUM_SIG*DATA_W  resolved values, same packing as drv_data
- any_forced  out  1  OR of all force-mask bits

Behaviour:
- Per-slot state: drv_q, frc_val, frc_mask.
- Resolved value per slot: (frc_val & frc_mask) | (drv_q & ~frc_mask). sig_out and any_forced are combinational from registers.
- Reset (rst high at a clk edge): all drv_q, frc_val, frc_mask = 0; state IDLE; rsp_valid = 0; rsp_data, rsp_fmask, rsp_err = 0. cmd_ready is held 0 while rst is high.
- Reset mid-operation: state returns to IDLE, rsp_valid is 0 in the cycle after, and the pending response is discarded.
- Driver path: drv_we[i] at an edge loads drv_q[i] <= drv_data slot i in every state. Forced bits stay masked on the output.
- FSM states: IDLE and RESP.
  - IDLE: cmd_ready = 1. A command is accepted on cmd_valid & cmd_ready. Acceptance executes the op at that edge and moves to RESP.
  - RESP: cmd_ready = 0, rsp_valid = 1. Outputs are held stable until rsp_ready; then return to IDLE.
  - Latency: accept at edge T, rsp_valid high after T. Minimum of 2 cycles per command; no back-to-back accept.
- FORCE (mask m, data d): frc_val <= (frc_val & ~m) | (d & m); frc_mask <= frc_mask | m. Overlapping re-force replaces only the masked bits.
- RELEASE (mask m):
  - Released bits that were forced retain the forced value: drv_q <= (drv_q & ~(m & frc_mask)) | (frc_val & m & frc_mask).
  - Then frc_mask <= frc_mask & ~m.
  - Released bits hold that value until the next drv_we (SV variable release semantics).
- READ and NOP: no state change.
- Response fields: rsp_data and rsp_fmask capture the slot's post-edge resolved value and mask at edge T, including any drv_we at T.
- rsp_err = 1 when cmd_addr >= NUM_SIG. In that case no state changes and rsp_data = rsp_fmask = 0.
- Simultaneous drv_we[i] and FORCE on slot i:
  - drv_q takes drv_data.
  - Bits under m show d.
  - Other bits show drv_data.
- Simultaneous drv_we[i] and RELEASE on slot i: the driver wins, so released bits show drv_data (assignment after release).
- mask = 0: valid no-op that still produces a response.

Optional Feature:
FORCE_OVERLAY_STATS_EN
- Defined:
  - Adds output ports force_cnt[15:0], release_cnt[15:0] and err_cnt[15:0].
  - Counters increment on accepted FORCE, accepted RELEASE, and responses with rsp_err, respectively.
  - Counters saturate at 16'hFFFF and are cleared by rst.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Full force:
  - Stimulus: drive slot 1 = 32'hAAAAAAAA each cycle, then FORCE addr 1, mask 32'hFFFFFFFF, data 32'h55555555.
  - Required: rsp_data = 32'h55555555 one cycle after accept; sig_out slot 1 stays 55555555 despite drv_we; any_forced = 1.
- Partial force:
  - Stimulus: slot 1 driven AAAAAAAA; FORCE mask 32'h0000FFFF, data 32'h5555.
  - Required: slot 1 = 32'hAAAA5555 and rsp_fmask = 0000FFFF.
  - Stimulus: then RELEASE mask 32'h0000FFFF.
  - Required: value holds AAAA5555 until the next drv_we, then returns to AAAAAAAA; any_forced = 0.
- Simultaneous driver write and release:
  - Stimulus: slot 3 forced to 8'h55 with full mask; RELEASE full mask at the same edge as drv_we with 8'hAA.
  - Required: sig_out slot 3 = 8'hAA after the edge.
- Response backpressure:
  - Stimulus: READ addr 2 with rsp_ready low for 5 cycles.
  - Required: rsp_valid, rsp_data and rsp_fmask stay stable; cmd_ready = 0 throughout; return to IDLE one cycle after rsp_ready.
- Error and reset:
  - Stimulus: FORCE addr 13.
  - Required: rsp_err = 1, no slot changes; err_cnt = 1 with FORCE_OVERLAY_STATS_EN.
  - Stimulus: assert rst while in RESP.
  - Required: rsp_valid = 0 and all sig_out = 0 the next cycle.
